// File: rtl/spi_input_conditioner.sv
// SPI pin front end: synchronize, debounce, edge-detect sclk/cs/mosi
// and count sclk rising edges within a chip-select frame.
module spi_input_conditioner #(
  parameter int WAIT_TIME = 3,
  parameter int CNT_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_raw,
  input  logic       cs_raw,
  input  logic       mosi_raw,
  output logic       sclk_cond,
  output logic       sclk_posedge,
  output logic       sclk_negedge,
  output logic       cs_cond,
  output logic       frame_start,
  output logic       frame_end,
  output logic       mosi_cond,
  output logic [3:0] bit_count,
  output logic       byte_done
);

  localparam int NCH = 3;
  // Channel order: bit 0 sclk, bit 1 cs, bit 2 mosi
  localparam logic [NCH-1:0] IDLE = 3'b010;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(WAIT_TIME - 1);

  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] cond_q, cond_d;
  logic [NCH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt_q [NCH];
  logic [CNT_WIDTH-1:0] cnt_d [NCH];

  logic sclk_pos_q, sclk_pos_d;
  logic sclk_neg_q, sclk_neg_d;
  logic fstart_q, fstart_d;
  logic fend_q, fend_d;
  logic [3:0] bit_count_q, bit_count_d;
  logic byte_done_q, byte_done_d;

  always_comb begin
    sync1_d = {mosi_raw, cs_raw, sclk_raw};
    sync2_d = sync1_q;
    cond_d  = cond_q;
    acc     = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != cond_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          acc[i]    = 1'b1;
          cond_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sclk_pos_d = acc[0] & sync2_q[0];
    sclk_neg_d = acc[0] & ~sync2_q[0];
    fstart_d   = acc[1] & ~sync2_q[1];
    fend_d     = acc[1] & sync2_q[1];
  end

  // A new frame clears the count and swallows a coincident sclk edge
  always_comb begin
    bit_count_d = bit_count_q;
    byte_done_d = 1'b0;
    if (fstart_q) begin
      bit_count_d = 4'd0;
    end else if (sclk_pos_q && !cond_q[1]) begin
      bit_count_d = bit_count_q + 4'd1;
      byte_done_d = (bit_count_q == 4'd7) ||
                    (bit_count_q == 4'd15);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= IDLE;
      sync2_q     <= IDLE;
      cond_q      <= IDLE;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      sclk_pos_q  <= 1'b0;
      sclk_neg_q  <= 1'b0;
      fstart_q    <= 1'b0;
      fend_q      <= 1'b0;
      bit_count_q <= 4'd0;
      byte_done_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cond_q      <= cond_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      sclk_pos_q  <= sclk_pos_d;
      sclk_neg_q  <= sclk_neg_d;
      fstart_q    <= fstart_d;
      fend_q      <= fend_d;
      bit_count_q <= bit_count_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign sclk_cond    = cond_q[0];
  assign cs_cond      = cond_q[1];
  assign mosi_cond    = cond_q[2];
  assign sclk_posedge = sclk_pos_q;
  assign sclk_negedge = sclk_neg_q;
  assign frame_start  = fstart_q;
  assign frame_end    = fend_q;
  assign bit_count    = bit_count_q;
  assign byte_done    = byte_done_q;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Bench for spi_input_conditioner: directed steps plus random pin
// activity, checked every cycle against a sliding-window model.
module tb_spi_input_conditioner;

  localparam int WT = 3;

  logic clk = 1'b0;
  logic reset;
  logic sclk_raw, cs_raw, mosi_raw;
  logic sclk_cond, sclk_posedge, sclk_negedge;
  logic cs_cond, frame_start, frame_end, mosi_cond;
  logic [3:0] bit_count;
  logic byte_done;

  int checks = 0;
  int errors = 0;

  int n_fs, n_fe, n_bd, n_pos;

  spi_input_conditioner #(.WAIT_TIME(WT), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .sclk_raw(sclk_raw), .cs_raw(cs_raw), .mosi_raw(mosi_raw),
    .sclk_cond(sclk_cond), .sclk_posedge(sclk_posedge),
    .sclk_negedge(sclk_negedge), .cs_cond(cs_cond),
    .frame_start(frame_start), .frame_end(frame_end),
    .mosi_cond(mosi_cond), .bit_count(bit_count),
    .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  // Model: a level is accepted once the last WT synchronized samples
  // (sync1 history, skipping the newest) all disagree with it.
  logic hist [3][WT+1];
  logic mc [3];
  logic mpos, mneg, mfs, mfe, mbd;
  int   mbits;

  function automatic logic idle_lvl(int ch);
    return (ch == 1);
  endfunction

  task automatic model_edge();
    logic raw [3];
    logic acc [3];
    int   nbits;
    logic nbd;
    raw[0] = sclk_raw; raw[1] = cs_raw; raw[2] = mosi_raw;
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        mc[c] = idle_lvl(c);
        for (int i = 0; i <= WT; i++) hist[c][i] = idle_lvl(c);
      end
      mpos = 0; mneg = 0; mfs = 0; mfe = 0; mbd = 0; mbits = 0;
      return;
    end
    nbits = mbits;
    nbd = 0;
    if (mfs) nbits = 0;
    else if (mpos && !mc[1]) begin
      nbits = (mbits + 1) % 16;
      nbd = (nbits == 8) || (nbits == 0);
    end
    for (int c = 0; c < 3; c++) begin
      acc[c] = 1;
      for (int i = 1; i <= WT; i++)
        if (hist[c][i] == mc[c]) acc[c] = 0;
    end
    mpos = acc[0] && !mc[0];
    mneg = acc[0] && mc[0];
    mfs  = acc[1] && mc[1];
    mfe  = acc[1] && !mc[1];
    for (int c = 0; c < 3; c++) begin
      if (acc[c]) mc[c] = !mc[c];
      for (int i = WT; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = raw[c];
    end
    mbits = nbits;
    mbd = nbd;
  endtask

  task automatic chk(string tag, logic o, logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk4(string tag, logic [3:0] o, logic [3:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic chki(string tag, int o, int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("sclk_cond", sclk_cond, mc[0]);
    chk("cs_cond", cs_cond, mc[1]);
    chk("mosi_cond", mosi_cond, mc[2]);
    chk("sclk_posedge", sclk_posedge, mpos);
    chk("sclk_negedge", sclk_negedge, mneg);
    chk("frame_start", frame_start, mfs);
    chk("frame_end", frame_end, mfe);
    chk("byte_done", byte_done, mbd);
    chk4("bit_count", bit_count, 4'(mbits));
    n_fs  += int'(frame_start);
    n_fe  += int'(frame_end);
    n_bd  += int'(byte_done);
    n_pos += int'(sclk_posedge);
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic sclk_periods(int n);
    repeat (n) begin
      sclk_raw = 1; hold(10);
      sclk_raw = 0; hold(10);
    end
  endtask

  initial begin
    logic [3:0] saved;
    n_fs = 0; n_fe = 0; n_bd = 0; n_pos = 0;

    // Reset with pins away from idle
    reset = 1; sclk_raw = 1; cs_raw = 0; mosi_raw = 1;
    hold(2);
    chk("rst_sclk", sclk_cond, 1'b0);
    chk("rst_cs", cs_cond, 1'b1);
    chk("rst_mosi", mosi_cond, 1'b0);
    chk4("rst_bits", bit_count, 4'd0);
    reset = 0;
    hold(4);
    chk("settle_early", sclk_cond, 1'b0);
    hold(1);
    chk("settle_sclk", sclk_cond, 1'b1);
    chk("settle_pos", sclk_posedge, 1'b1);

    sclk_raw = 0; cs_raw = 1; mosi_raw = 0;
    hold(12);

    // Clean sclk rise latency
    sclk_raw = 1;
    hold(4);
    chk("lat_k3", sclk_cond, 1'b0);
    hold(1);
    chk("lat_k4_cond", sclk_cond, 1'b1);
    chk("lat_k4_pos", sclk_posedge, 1'b1);
    hold(1);
    chk("lat_k5_pos", sclk_posedge, 1'b0);
    sclk_raw = 0; hold(10);

    // Glitch rejection then acceptance
    mosi_raw = 1; hold(2);
    mosi_raw = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_mosi", mosi_cond, 1'b0);
    end
    mosi_raw = 1; hold(3);
    mosi_raw = 0; hold(2);
    chk("pulse3_mosi", mosi_cond, 1'b1);
    hold(10);

    // Full 16-bit frame
    n_fs = 0; n_fe = 0; n_bd = 0;
    cs_raw = 0; hold(10);
    sclk_periods(16);
    chk4("frame_wrap", bit_count, 4'd0);
    cs_raw = 1; hold(10);
    chki("frame_start_cnt", n_fs, 1);
    chki("byte_done_cnt", n_bd, 2);
    chki("frame_end_cnt", n_fe, 1);

    // sclk activity with cs deasserted
    n_pos = 0; n_bd = 0; saved = bit_count;
    sclk_periods(3);
    chki("cs_hi_pos", n_pos, 3);
    chki("cs_hi_bd", n_bd, 0);
    chk4("cs_hi_bits", bit_count, saved);

    // Reset mid-frame
    cs_raw = 0; hold(10);
    sclk_periods(5);
    chk4("mid_bits", bit_count, 4'd5);
    n_fe = 0;
    reset = 1; cs_raw = 1;
    tick();
    chk("mrst_cs", cs_cond, 1'b1);
    chk4("mrst_bits", bit_count, 4'd0);
    reset = 0; hold(10);
    chki("mrst_no_fe", n_fe, 0);
    cs_raw = 0; hold(10);
    sclk_periods(2);
    chk4("restart_bits", bit_count, 4'd2);
    cs_raw = 1; hold(10);

    // Random pin activity, including glitches and occasional reset
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 2) == 0) sclk_raw = ~sclk_raw;
      if ($urandom_range(0, 9) == 0) cs_raw = ~cs_raw;
      if ($urandom_range(0, 3) == 0) mosi_raw = ~mosi_raw;
      hold(reset ? 1 : $urandom_range(1, 6));
    end
    reset = 0;
    hold(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_input_conditioner.md
Name: spi_input_conditioner

Overview:
Front end between the raw SPI pins and the SPI slave FSM. Each of the three inputs (sclk, cs, mosi) passes through a 2-flop synchronizer and a debounce filter in the clk domain. The block then emits conditioned levels and single-cycle edge pulses, and keeps a frame bit counter. The FSM consumes sclk_posedge and sclk_negedge as its shift strobes instead of clocking on raw sclk.

Parameters:
WAIT_TIME, 3, number of consecutive clk cycles a synchronized level must differ from the conditioned level before it is accepted (legal range 1..(2^CNT_WIDTH)-1)
CNT_WIDTH, 3, width of each per-channel debounce counter

Ports:
clk  input  1  FPGA clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
sclk_raw  input  1  asynchronous SPI clock pin
cs_raw  input  1  asynchronous SPI chip select pin, active low
mosi_raw  input  1  asynchronous SPI master-out slave-in pin
sclk_cond  output  1  debounced SPI clock level
sclk_posedge  output  1  one-cycle pulse when sclk_cond rises
sclk_negedge  output  1  one-cycle pulse when sclk_cond falls
cs_cond  output  1  debounced chip select level
frame_start  output  1  one-cycle pulse when cs_cond falls
frame_end  output  1  one-cycle pulse when cs_cond rises
mosi_cond  output  1  debounced MOSI level
bit_count  output  4  sclk rising edges counted since frame_start
byte_done  output  1  one-cycle pulse on the sclk_posedge that completes bits 8 and 16

Behaviour:
- Reset is synchronous and active-high; reset has priority over every other update. Reset values:
  - sync flops and conditioned levels take the idle pin levels: sclk 0, cs 1, mosi 0.
  - all debounce counters 0; bit_count 0; all pulse outputs 0.
- Reset asserted mid-frame aborts the frame. No frame_end pulse is generated.
- Per channel, identical logic: sync1 <= raw; sync2 <= sync1.
  - sync2 == cond: counter <= 0.
  - sync2 != cond and counter == WAIT_TIME-1: cond <= sync2, counter <= 0, and the matching edge pulse is registered high.
  - Otherwise counter <= counter+1.
- Latency: a clean level change is first sampled by sync1 on edge k. cond and the pulse update on edge k+WAIT_TIME+1, i.e. the (WAIT_TIME+2)th edge counting k.
- Glitches: if sync2 returns to cond before acceptance, the counter clears and no pulse or level change occurs.
- Pulses are registered and high for exactly one clk cycle. A channel cannot pulse on consecutive cycles.
- mosi has no edge outputs.
- Frame counter:
  - frame_start cycle (registered cs fall): bit_count <= 0. This takes priority over a coincident sclk_posedge, which is not counted.
  - sclk_posedge while cs_cond == 0 and no frame_start: bit_count <= bit_count+1, wrapping 15 -> 0.
  - byte_done is registered high for one cycle when the increment takes bit_count from 7 to 8 or from 15 to 0.
  - sclk_posedge while cs_cond == 1: pulse still output; bit_count and byte_done unchanged.
  - frame_end: bit_count holds its value until the next frame_start or reset.
- Channels are independent. Simultaneous edges on different channels each produce their own pulse in the same cycle.

Test Plan:
1. Assert reset for 2 cycles with raw pins at 1/0/1 (sclk/cs/mosi) -> sclk_cond=0, cs_cond=1, mosi_cond=0, bit_count=0, no pulses. Pins then settle: sclk_cond rises, with sclk_posedge, 5 edges after release.
2. WAIT_TIME=3; hold cs_raw at 1, drive sclk_raw 0->1 before edge k -> sclk_cond=1 and sclk_posedge=1 after edge k+4; sclk_posedge=0 after edge k+5.
3. 2-cycle high glitch on mosi_raw (WAIT_TIME=3) -> mosi_cond stays 0 and the counter returns to 0. A 3-cycle pulse of the same shape is accepted.
4. Full frame: cs low, then 16 clean sclk periods of 10 clk each high and low -> frame_start once, bit_count reaches 16 (wraps to 0), byte_done at bits 8 and 16, then frame_end after cs goes high.
5. 3 sclk periods with cs high -> 3 sclk_posedge pulses, bit_count unchanged, no byte_done.
6. Reset asserted after bit 5 of a frame -> all outputs to reset values on the next edge, no frame_end. A new cs fall restarts counting from 0.
